// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
// Holds the FSM state encoding and default frame byte values.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_EXEC,
        ALU_WAIT,
        SEND_LO,
        SEND_HI,
        SEND_ERR
    } state_e;

    localparam logic [7:0] CMD_ALU_OP_DEF    = 8'hCC;
    localparam logic [7:0] CMD_ALU_REUSE_DEF = 8'hDD;
    localparam logic [7:0] ERR_BYTE_DEF      = 8'hEE;

    localparam int MAX_FUN = 13;

    function automatic logic is_send(input state_e s);
        return (s == SEND_LO) || (s == SEND_HI) || (s == SEND_ERR);
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command frame parser driving the ALU; returns the 16-bit result
// to the TX FIFO as two bytes, LSB first, or one error byte.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP    = DATA_WIDTH'(CMD_ALU_OP_DEF),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_REUSE = DATA_WIDTH'(CMD_ALU_REUSE_DEF),
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE      = DATA_WIDTH'(ERR_BYTE_DEF)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_FULL,
    output logic                    BUSY
);

    localparam logic [FUN_WIDTH-1:0] FUN_LIMIT = FUN_WIDTH'(MAX_FUN);

    state_e                  state;
    state_e                  nxt;
    logic [2*DATA_WIDTH-1:0] result;
    logic [FUN_WIDTH-1:0]    fun_in;
    logic                    fun_ok;

    assign fun_in = RX_P_DATA[FUN_WIDTH-1:0];
    assign fun_ok = (fun_in <= FUN_LIMIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Operands persist across frames so a reuse header can replay them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_FUN <= '0;
        end else if (RX_D_VLD) begin
            if (state == GET_A) begin
                ALU_A <= RX_P_DATA;
            end
            if (state == GET_B) begin
                ALU_B <= RX_P_DATA;
            end
            if (state == GET_FUN) begin
                ALU_FUN <= fun_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result <= '0;
        end else if (state == ALU_WAIT && ALU_OUT_VLD) begin
            result <= ALU_OUT;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OP) begin
                        nxt = GET_A;
                    end else if (RX_P_DATA == CMD_ALU_REUSE) begin
                        nxt = GET_FUN;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) nxt = GET_B;
            end
            GET_B: begin
                if (RX_D_VLD) nxt = GET_FUN;
            end
            GET_FUN: begin
                if (RX_D_VLD) nxt = fun_ok ? ALU_EXEC : SEND_ERR;
            end
            ALU_EXEC: nxt = ALU_WAIT;
            ALU_WAIT: begin
                if (ALU_OUT_VLD) nxt = SEND_LO;
            end
            SEND_LO: begin
                if (!TX_FULL) nxt = SEND_HI;
            end
            SEND_HI: begin
                if (!TX_FULL) nxt = IDLE;
            end
            SEND_ERR: begin
                if (!TX_FULL) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Byte selection depends only on state, so it is stable while FIFO is full.
    always_comb begin
        TX_P_DATA = '0;
        unique case (state)
            SEND_LO:  TX_P_DATA = result[DATA_WIDTH-1:0];
            SEND_HI:  TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
            SEND_ERR: TX_P_DATA = ERR_BYTE;
            default:  TX_P_DATA = '0;
        endcase
    end

    assign TX_D_VLD = is_send(state) && !TX_FULL;
    assign ALU_EN   = (state == ALU_EXEC);
    assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized bench for alu_cmd_ctrl with a frame-level reference model
// and a behavioural ALU answering each enable one cycle later.
module tb_alu_cmd_ctrl;

    localparam logic [7:0] C_OP  = 8'hCC;
    localparam logic [7:0] C_RE  = 8'hDD;
    localparam logic [7:0] C_ERR = 8'hEE;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_FULL;
    logic        BUSY;

    alu_cmd_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALU_FUN     (ALU_FUN),
        .ALU_EN      (ALU_EN),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .TX_FULL     (TX_FULL),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         e;
    } txe_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        int         e;
    } ene_t;

    txe_t exp_q[$];
    ene_t en_q[$];
    txe_t mon_t;
    ene_t mon_e;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [3:0] m_f = 4'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [3:0] f);
        logic [15:0] ua;
        logic [15:0] ub;
        ua = {8'h00, a};
        ub = {8'h00, b};
        case (f)
            4'd0:    return ua + ub;
            4'd1:    return ua - ub;
            4'd2:    return ua * ub;
            4'd3:    return ua & ub;
            4'd4:    return ua | ub;
            4'd5:    return {8'h00, ~(a & b)};
            4'd6:    return {8'h00, ~(a | b)};
            4'd7:    return ua ^ ub;
            4'd8:    return {8'h00, ~(a ^ b)};
            4'd9:    return (a > b) ? 16'd1 : 16'd0;
            4'd10:   return (a == b) ? 16'd1 : 16'd0;
            4'd11:   return (a < b) ? 16'd1 : 16'd0;
            4'd12:   return ua >> 1;
            4'd13:   return ua << 1;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural ALU: registers its result on the edge that sees ALU_EN.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT_VLD <= 1'b0;
            ALU_OUT     <= 16'h0000;
        end else begin
            ALU_OUT_VLD <= ALU_EN;
            if (ALU_EN) ALU_OUT <= alu_fn(ALU_A, ALU_B, ALU_FUN);
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            chk("tx_vld_full", 32'(TX_D_VLD & TX_FULL), 0);
            if (TX_D_VLD && !TX_FULL) begin
                chk("tx_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_t = exp_q.pop_front();
                    chk("tx_data", 32'(TX_P_DATA), 32'(mon_t.d));
                    chk("tx_edge", cyc, mon_t.e);
                end
            end
            if (ALU_EN) begin
                chk("en_pending", 32'(en_q.size() != 0), 1);
                if (en_q.size() != 0) begin
                    mon_e = en_q.pop_front();
                    chk("en_a", 32'(ALU_A), 32'(mon_e.a));
                    chk("en_b", 32'(ALU_B), 32'(mon_e.b));
                    chk("en_fun", 32'(ALU_FUN), 32'(mon_e.f));
                    chk("en_edge", cyc, mon_e.e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = $urandom;
    endtask

    // Edges are labelled by the count of earlier edges; after a byte
    // sampled at edge k, cyc reads k+1.
    task automatic run_frame(input bit reuse, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] fb,
                             input int full, input bit inject,
                             input bit tail);
        int          fe;
        int          done;
        logic [15:0] r;
        logic [3:0]  f;
        if (!reuse) begin
            send_byte(C_OP);
            send_byte(a);
            send_byte(b);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(C_RE);
        end
        send_byte(fb);
        fe  = cyc - 1;
        f   = fb[3:0];
        m_f = f;
        if (f <= 4'd13) begin
            r = alu_fn(m_a, m_b, f);
            en_q.push_back('{m_a, m_b, f, fe + 1});
            exp_q.push_back('{r[7:0], fe + 3 + full});
            exp_q.push_back('{r[15:8], fe + 4 + full});
            done = fe + 4 + full;
        end else begin
            exp_q.push_back('{C_ERR, fe + 1});
            done = fe + 1;
        end
        chk("busy_run", 32'(BUSY), 1);
        if (full > 0) begin
            TX_FULL = 1'b1;
            idle(2 + full);
            TX_FULL = 1'b0;
        end else if (inject) begin
            idle(1);
            send_byte(C_OP);
            send_byte(8'($urandom));
        end
        if (tail) begin
            while (cyc < fe + 4) idle(1);
            send_byte(C_RE);
        end else begin
            while (cyc < done) idle(1);
            chk("busy_last", 32'(BUSY), 1);
            idle(1);
            chk("busy_done", 32'(BUSY), 0);
            chk("hold_a", 32'(ALU_A), 32'(m_a));
            chk("hold_b", 32'(ALU_B), 32'(m_b));
            chk("hold_fun", 32'(ALU_FUN), 32'(m_f));
        end
    endtask

    initial begin
        int          fe;
        logic [7:0]  g;
        logic [7:0]  fb;
        int          full;
        bit          inj;
        bit          tl;
        RST       = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_FULL   = 1'b0;
        @(posedge CLK);
        #1;
        idle(2);
        chk("rst_a", 32'(ALU_A), 0);
        chk("rst_b", 32'(ALU_B), 0);
        chk("rst_fun", 32'(ALU_FUN), 0);
        chk("rst_en", 32'(ALU_EN), 0);
        chk("rst_txd", 32'(TX_P_DATA), 0);
        chk("rst_txv", 32'(TX_D_VLD), 0);
        chk("rst_busy", 32'(BUSY), 0);
        RST = 1'b1;
        idle(2);

        run_frame(1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run_frame(0, 8'h05, 8'h03, 8'h00, 0, 0, 0);
        run_frame(0, 8'hFF, 8'hFF, 8'h02, 0, 0, 0);
        run_frame(1, 8'h00, 8'h00, 8'h0A, 0, 0, 0);
        run_frame(0, 8'h02, 8'h03, 8'h02, 5, 0, 0);
        run_frame(0, 8'h11, 8'h22, 8'h0E, 0, 0, 0);
        run_frame(1, 8'h00, 8'h00, 8'hAF, 0, 0, 0);

        send_byte(8'h55);
        idle(3);
        chk("garbage_busy", 32'(BUSY), 0);

        run_frame(0, 8'h40, 8'h07, 8'h01, 0, 1, 0);
        run_frame(0, 8'h09, 8'h04, 8'h00, 0, 0, 1);
        run_frame(0, 8'h30, 8'h03, 8'h0D, 0, 0, 0);

        send_byte(C_OP);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h02);
        fe = cyc - 1;
        en_q.push_back('{8'h02, 8'h03, 4'h2, fe + 1});
        TX_FULL = 1'b1;
        idle(3);
        chk("mid_busy", 32'(BUSY), 1);
        RST = 1'b0;
        #1;
        chk("mid_a", 32'(ALU_A), 0);
        chk("mid_b", 32'(ALU_B), 0);
        chk("mid_fun", 32'(ALU_FUN), 0);
        chk("mid_txv", 32'(TX_D_VLD), 0);
        chk("mid_txd", 32'(TX_P_DATA), 0);
        chk("mid_busy_lo", 32'(BUSY), 0);
        idle(2);
        RST     = 1'b1;
        TX_FULL = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_f = 4'h0;
        idle(6);
        chk("mid_after_busy", 32'(BUSY), 0);
        run_frame(1, 8'h00, 8'h00, 8'h0B, 0, 0, 0);
        run_frame(0, 8'h81, 8'h7F, 8'h00, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == C_OP || g == C_RE) g = 8'h55;
                send_byte(g);
            end
            idle($urandom_range(0, 2));
            fb   = 8'($urandom);
            full = 0;
            inj  = 0;
            tl   = 0;
            if (fb[3:0] <= 4'd13) begin
                full = $urandom_range(0, 3);
                if (full == 0) begin
                    inj = 1'($urandom);
                    tl  = 1'($urandom);
                end
            end
            run_frame($urandom_range(0, 9) < 3, 8'($urandom), 8'($urandom),
                      fb, full, inj, tl);
        end

        idle(8);
        chk("exp_drained", exp_q.size(), 0);
        chk("en_drained", en_q.size(), 0);
        chk("end_busy", 32'(BUSY), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
